stg_uop_fold: RTL

- Inverse of the translate stage: watches the micro-op stream and folds the call and return expansion sequences back into the single ISA word that produced them.
- Non-matching micro-ops pass through unchanged.
- Sits at the retire/trace tap, feeding the debug trace sink and retired-instruction counters with architectural (macro) instructions.
- Uses a 3-entry match buffer, a match FSM and a 1-entry output register with valid/ready flow control.

---
 rtl/stg_uop_fold_if.sv | 46 ++++
 rtl/stg_uop_fold.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/stg_uop_fold_if.sv
// ISA field encodings shared with stg_uop_fold, and the micro-op in / macro-op out handshake bundle.
`ifndef STG_UOP_FOLD_DEFS
`define STG_UOP_FOLD_DEFS
`define SIZE_ADDR    16
`define SIZE_DATA    24
`define OPC_SRSUBsi  8'h10
`define OPC_SRADDsi  8'h11
`define OPC_SRSTso   8'h12
`define OPC_SRLDso   8'h13
`define OPC_SRMOVur  8'h14
`define OPC_SRJCCso  8'h15
`define OPC_JCCui    8'h20
`define OPC_BCCsr    8'h21
`define OPC_BALso    8'h22
`define OPC_JSRui    8'h30
`define OPC_BSRsr    8'h31
`define OPC_BSRso    8'h32
`define OPC_RET      8'h33
`define SR_IDX_SSP   2'd1
`define SR_IDX_LR    2'd2
`define SR_IDX_PC    2'd3
`endif

interface stg_uop_fold_if;
    logic                  iw_valid;
    logic                  ow_ready;
    logic [`SIZE_ADDR-1:0] iw_pc;
    logic [`SIZE_DATA-1:0] iw_instr;
    logic                  iw_flush;
    logic                  ow_valid;
    logic                  iw_ready;
    logic [`SIZE_ADDR-1:0] ow_pc;
    logic [`SIZE_DATA-1:0] ow_instr;
    logic                  ow_fused;
    logic [2:0]            ow_uop_cnt;

    modport slave (
        input  iw_valid, iw_pc, iw_instr, iw_flush, iw_ready,
        output ow_ready, ow_valid, ow_pc, ow_instr, ow_fused, ow_uop_cnt
    );

    modport master (
        output iw_valid, iw_pc, iw_instr, iw_flush, iw_ready,
        input  ow_ready, ow_valid, ow_pc, ow_instr, ow_fused, ow_uop_cnt
    );
endinterface

// File: rtl/stg_uop_fold.sv
// Folds call (A,B,C,D) and return (R0,R1,R2) micro-op expansions back into one macro word;
// everything else passes through a single output register with valid/ready flow control.
module stg_uop_fold #(
    parameter int MAX_BUF = 3
) (
    input  logic          iw_clk,
    input  logic          iw_rst,
    stg_uop_fold_if.slave bus
);
    localparam int AW = `SIZE_ADDR;
    localparam int DW = `SIZE_DATA;
    localparam int CW = $clog2(MAX_BUF + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_C1, S_C2, S_C3, S_R1, S_R2, S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   buf_q [MAX_BUF];
    logic [CW-1:0]   buf_cnt_q, rd_idx_q;
    logic [AW-1:0]   pc_q;

    logic            valid_q, fused_q;
    logic [AW-1:0]   out_pc_q;
    logic [DW-1:0]   out_instr_q;
    logic [2:0]      out_cnt_q;

    logic [7:0]      opc;
    logic [15:0]     pl;
    logic            is_a, is_b, is_c, is_d, is_r0, is_r1, is_r2;
    logic            load_en, same_pc, partial, match_ok, mismatch, ready, accept;
    logic            push, pop, emit, emit_fused;
    logic [2:0]      emit_cnt;
    logic [AW-1:0]   emit_pc;
    logic [DW-1:0]   emit_instr, fold_call;

    assign opc = bus.iw_instr[DW-1 -: 8];
    assign pl  = bus.iw_instr[15:0];

    assign is_a  = (opc == `OPC_SRSUBsi) && (pl[15:14] == `SR_IDX_SSP) && (pl[13:0] == 14'd2);
    assign is_b  = (opc == `OPC_SRSTso) && (pl[15:14] == `SR_IDX_SSP) && (pl[13:12] == `SR_IDX_LR)
                   && (pl[11:0] == 12'd0);
    assign is_c  = (opc == `OPC_SRMOVur) && (pl[15:14] == `SR_IDX_LR) && (pl[13:12] == `SR_IDX_PC)
                   && (pl[11:0] == 12'd0);
    assign is_d  = ((opc == `OPC_JCCui) && (pl[15:12] == 4'd0))
                || ((opc == `OPC_BCCsr) && (pl[11:8] == 4'd0) && (pl[7:0] == 8'd0))
                || (opc == `OPC_BALso);
    assign is_r0 = (opc == `OPC_SRADDsi) && (pl[15:14] == `SR_IDX_SSP) && (pl[13:0] == 14'd2);
    assign is_r1 = (opc == `OPC_SRLDso) && (pl[15:14] == `SR_IDX_LR) && (pl[13:12] == `SR_IDX_SSP)
                   && (pl[11:0] == 12'hFFE);
    assign is_r2 = (opc == `OPC_SRJCCso) && (pl[15:14] == `SR_IDX_LR) && (pl[13:10] == 4'd0)
                   && (pl[9:0] == 10'd1);

    assign load_en = !valid_q || bus.iw_ready;
    assign same_pc = (bus.iw_pc == pc_q);

    // The call form depends only on which terminating branch closed the sequence.
    always_comb begin
        fold_call = {`OPC_BSRso, pl};
        if (opc == `OPC_JCCui)
            fold_call = {`OPC_JSRui, 4'b0, pl[11:0]};
        else if (opc == `OPC_BCCsr)
            fold_call = {`OPC_BSRsr, pl[15:12], 12'b0};
    end

    // NOTE: every signal written here gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        partial    = 1'b1;
        match_ok   = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        emit       = 1'b0;
        emit_fused = 1'b0;
        emit_cnt   = 3'd1;
        emit_pc    = bus.iw_pc;
        emit_instr = bus.iw_instr;

        case (state_q)
            S_C1:    match_ok = is_b  && same_pc;
            S_C2:    match_ok = is_c  && same_pc;
            S_C3:    match_ok = is_d  && same_pc;
            S_R1:    match_ok = is_r1 && same_pc;
            S_R2:    match_ok = is_r2 && same_pc;
            default: partial  = 1'b0;
        endcase

        mismatch = partial && bus.iw_valid && !match_ok;
        ready    = load_en && !bus.iw_flush && (state_q != S_DRAIN) && !mismatch;
        accept   = bus.iw_valid && ready;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_a) begin
                        push    = 1'b1;
                        state_d = S_C1;
                    end else if (is_r0) begin
                        push    = 1'b1;
                        state_d = S_R1;
                    end else begin
                        emit    = 1'b1;
                    end
                end
            end
            S_C1, S_C2, S_R1: begin
                if (accept) begin
                    push    = 1'b1;
                    state_d = (state_q == S_C1) ? S_C2 : (state_q == S_C2) ? S_C3 : S_R2;
                end else if (mismatch) begin
                    state_d = S_DRAIN;
                end
            end
            S_C3, S_R2: begin
                if (accept) begin
                    emit       = 1'b1;
                    emit_fused = 1'b1;
                    emit_pc    = pc_q;
                    emit_cnt   = (state_q == S_C3) ? 3'd4 : 3'd3;
                    emit_instr = (state_q == S_C3) ? fold_call : {`OPC_RET, 16'b0};
                    state_d    = S_IDLE;
                end else if (mismatch) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (load_en && !bus.iw_flush) begin
                    emit       = 1'b1;
                    pop        = 1'b1;
                    emit_pc    = pc_q;
                    emit_instr = buf_q[rd_idx_q];
                    if (rd_idx_q + 1'b1 == buf_cnt_q)
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the match buffer is plain storage qualified by buf_cnt_q, so it carries no reset.
    always_ff @(posedge iw_clk) begin
        if (push)
            buf_q[buf_cnt_q] <= bus.iw_instr;
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst || bus.iw_flush) begin
            state_q   <= S_IDLE;
            buf_cnt_q <= '0;
            rd_idx_q  <= '0;
            pc_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == S_IDLE) begin
                buf_cnt_q <= '0;
                rd_idx_q  <= '0;
            end else begin
                if (push) buf_cnt_q <= buf_cnt_q + 1'b1;
                if (pop)  rd_idx_q  <= rd_idx_q + 1'b1;
            end
            if (push && state_q == S_IDLE)
                pc_q <= bus.iw_pc;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst || bus.iw_flush) begin
            valid_q     <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
            fused_q     <= 1'b0;
            out_cnt_q   <= 3'd0;
        end else if (load_en) begin
            valid_q <= emit;
            if (emit) begin
                out_pc_q    <= emit_pc;
                out_instr_q <= emit_instr;
                fused_q     <= emit_fused;
                out_cnt_q   <= emit_cnt;
            end
        end
    end

    assign bus.ow_ready   = ready;
    assign bus.ow_valid   = valid_q;
    assign bus.ow_pc      = out_pc_q;
    assign bus.ow_instr   = out_instr_q;
    assign bus.ow_fused   = fused_q;
    assign bus.ow_uop_cnt = out_cnt_q;
endmodule
